hidden_cpu_feeder: RTL and testbench
====================================

# hidden_cpu_feeder

Host-side program feeder for the hidden CPU. It buffers a program of 6-bit instruction words loaded over a valid/ready port. It then drives the CPU's reset and instruction pins (`io_in[7:1]`), and captures the CPU's `io_out` result stream back to the host. It is the counterpart of the CPU core: the core consumes one instruction per clock and emits r3/pc, and this block supplies those instructions and collects the outputs.

## Interface
Parameters:
- `DEPTH`, 32: program buffer entries (power of two).
- `AW`, 5: log2(DEPTH).
- `MAX_CYCLES`, 255: run-length limit in clocks; counter is 8 bits.

Ports:
- `clk` in 1: single clock, shared with the CPU.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: program word offered.
- `load_ready` out 1: buffer accepts a word. High only in IDLE with count < DEPTH.
- `load_data` in 6: instruction word in CPU format: [5:4] opcode, [3:2] rA, [1:0] rB.
- `clear` in 1: empties the program buffer. Honoured in IDLE only.
- `start` in 1: begin a run. Ignored unless in IDLE with count > 0.
- `follow_pc` in 1: sampled at `start`. 1 = fetch address comes from CPU pc. 0 = fetch address comes from the local counter.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on return to IDLE after a run.
- `cpu_rst` out 1: drives CPU `io_in[1]` (active-high).
- `cpu_instr` out 6: drives CPU `io_in[7:2]`.
- `cpu_out` in 8: CPU `io_out`.
- `cap_valid` out 1: captured sample valid.
- `cap_data` out 8: captured `cpu_out`.

## Operation
- The program buffer is a DEPTH x 6 register array with write pointer `count` (AW+1 bits).
- A load handshake completes on `load_valid & load_ready`. The word is written at `mem[count]` and `count` increments.
- A word offered when `count == DEPTH` is not accepted; `load_ready` is low.
- `clear` resets `count` to 0. Memory contents are left unchanged.
- State machine:
  - IDLE: on `start` with `count > 0`, latch `follow_pc`, set `cyc=0`, go to RESET.
  - RESET: `cpu_rst=1`, `cpu_instr=0` for exactly 2 clocks, then go to RUN.
  - RUN: `cpu_rst=0`; `cpu_instr = mem[fa]`, read combinationally.
    - In local mode, `fa = cyc[AW-1:0]`.
    - In follow mode, `fa = cpu_out[AW-1:0]`.
    - `cyc` increments every clock.
    - RUN ends (go to DRAIN) on the first of:
      - local mode: `cyc == count-1` is being issued;
      - follow mode: `cpu_out >= count`, checked before issue, so no instruction is issued that cycle and `cpu_instr=0`;
      - `cyc == MAX_CYCLES`;
      - `stop` asserted.
  - DRAIN: 1 clock, `cpu_instr=0`, capture the final result. Then go to IDLE with `done=1`.
- Capture: `cap_data <= cpu_out` and `cap_valid <= 1` on every clock spent in RUN or DRAIN; otherwise `cap_valid <= 0`.
- `start` while busy is ignored. `load_valid` while busy is not accepted.

## Timing
- Reset values:
  - State IDLE.
  - `count=0`, `cyc=0`.
  - `load_ready=1`.
  - `busy=0`, `done=0`.
  - `cpu_rst=1`: the CPU is held in reset while the feeder is in reset and in IDLE.
  - `cpu_instr=0`.
  - `cap_valid=0`, `cap_data=0`.
- Cycle from `start` high at edge N:
  - `busy` rises after N.
  - RESET occupies edges N+1 and N+2.
  - The first instruction is presented after N+2 and executed by the CPU at N+3.
- Latency: `cap_data` shows the result of the instruction executed at edge E after edge E+1. It is valid with `cap_valid` for that cycle.
- A local-mode run of L words takes 2 + L + 1 clocks, start to `done`.
- If `rst_n` falls mid-run, everything returns to reset values immediately: `cpu_rst=1`, no `done` pulse.
- If `stop` and the last-instruction condition occur in the same cycle, that instruction is still issued. Both cases take the same DRAIN path.
- `cyc` saturates at MAX_CYCLES and never wraps.

## Structure
- Shared package `hidden_cpu_pkg`, with:
  - opcode constants (ALU=2'b00 … 2'b11);
  - instruction field slice positions;
  - CPU pin map (clk=0, rst=1, instr=7:2);
  - the state enum {IDLE, RESET, RUN, DRAIN}.
- One natural sub-module, `prog_buffer`: register array with a write port and a combinational read port.

## Test plan
- Load 3 words 0x05, 0x2A, 0x3F, then `start` in local mode. Required response:
  - `cpu_rst` high for 2 clocks;
  - `cpu_instr` presents 0x05, 0x2A, 0x3F on consecutive clocks;
  - `done` pulses at clock 6 after start;
  - `cap_valid` is high for 4 clocks.
- Load 32 words. `load_ready` drops after the 32nd; a 33rd `load_valid` is not written and `count` stays 32.
- Follow mode with `count=4` and `cpu_out` forced to 0, 1, 2, 7. Required response: `cpu_instr` presents mem[0], mem[1], mem[2], then 0; RUN ends and `done` pulses.
- Raise `stop` on the second RUN clock of an 8-word program. Exactly 2 instructions are issued, then DRAIN, then `done`.
- Assert `rst_n=0` during RUN. Required response: asynchronously `busy=0`, `cpu_rst=1`, `count=0`, `cap_valid=0`; no `done` pulse.
- Run with a 1-word program looping in follow mode, with `cpu_out` stuck at 0. RUN terminates at `cyc=255`, followed by a `done` pulse.

Source files
------------

// File: rtl/hidden_cpu_pkg.sv
// ============================================================================
// Module  : hidden_cpu_pkg
// Brief   : Shared definitions for the hidden CPU and its program feeder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hidden_cpu_pkg;

    // CPU pin map on io_in
    localparam int c_pinClk     = 0;
    localparam int c_pinRst     = 1;
    localparam int c_pinInstrLo = 2;
    localparam int c_pinInstrHi = 7;
    localparam int c_instrW     = c_pinInstrHi - c_pinInstrLo + 1;

    // Instruction fields: [5:4] opcode, [3:2] rA, [1:0] rB
    localparam int c_opHi = 5;
    localparam int c_opLo = 4;
    localparam int c_raHi = 3;
    localparam int c_raLo = 2;
    localparam int c_rbHi = 1;
    localparam int c_rbLo = 0;

    localparam logic [1:0] c_opAlu = 2'b00;
    localparam logic [1:0] c_opLdi = 2'b01;
    localparam logic [1:0] c_opBrz = 2'b10;
    localparam logic [1:0] c_opOut = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } feeder_state_t;

    function automatic logic [1:0] instrOpcode(input logic [c_instrW-1:0] instr);
        return instr[c_opHi:c_opLo];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hidden_cpu_feeder_prog_buffer.sv
// ============================================================================
// Module  : prog_buffer
// Brief   : Program store, one synchronous write port, one combinational read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             i_wrEn,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents survive reset and clear; only the fill pointer is reset.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

`default_nettype wire

// File: rtl/hidden_cpu_feeder.sv
// ============================================================================
// Module  : hidden_cpu_feeder
// Brief   : Buffers a program, sequences the CPU through reset and run, and
//           captures the CPU result stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hidden_cpu_feeder
    import hidden_cpu_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int AW         = 5,
    parameter int MAX_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [c_instrW-1:0] load_data,
    input  logic                clear,
    input  logic                start,
    input  logic                follow_pc,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic                cpu_rst,
    output logic [c_instrW-1:0] cpu_instr,
    input  logic [7:0]          cpu_out,
    output logic                cap_valid,
    output logic [7:0]          cap_data
);

    localparam logic [7:0]  c_maxCyc = 8'(MAX_CYCLES);
    localparam logic [AW:0] c_depth  = (AW+1)'(DEPTH);

    feeder_state_t       r_state;
    logic [AW:0]         r_count;
    logic [7:0]          r_cyc;
    logic                r_follow;
    logic                r_rstSecond;
    logic                r_busy;
    logic                r_done;
    logic                r_cpuRst;
    logic                r_capValid;
    logic [7:0]          r_capData;

    logic                w_loadFire;
    logic                w_lastLocal;
    logic                w_followEnd;
    logic                w_runEnd;
    logic [7:0]          w_count8;
    logic [AW-1:0]       w_fetchAddr;
    logic [c_instrW-1:0] w_rdData;

    always_comb begin
        w_count8    = 8'(r_count);
        load_ready  = (r_state == IDLE) && (r_count < c_depth) && !clear;
        w_loadFire  = load_valid && load_ready;
        w_fetchAddr = r_follow ? cpu_out[AW-1:0] : r_cyc[AW-1:0];
        w_lastLocal = !r_follow && (r_cyc == w_count8 - 8'd1);
        // An out-of-range pc ends the run before anything is issued.
        w_followEnd = r_follow && (cpu_out >= w_count8);
        w_runEnd    = w_lastLocal || w_followEnd || (r_cyc == c_maxCyc) || stop;
        cpu_instr   = ((r_state == RUN) && !w_followEnd) ? w_rdData : '0;
    end

    prog_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (c_instrW)
    ) u_progBuffer (
        .clk      (clk),
        .i_wrEn   (w_loadFire),
        .i_wrAddr (r_count[AW-1:0]),
        .i_wrData (load_data),
        .i_rdAddr (w_fetchAddr),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_cyc       <= '0;
            r_follow    <= 1'b0;
            r_rstSecond <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cpuRst    <= 1'b1;
            r_capValid  <= 1'b0;
            r_capData   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Clear takes priority over a simultaneous start.
                    if (clear) begin
                        r_count <= '0;
                    end else begin
                        if (w_loadFire) begin
                            r_count <= r_count + (AW+1)'(1);
                        end
                        if (start && (r_count != '0)) begin
                            r_follow    <= follow_pc;
                            r_cyc       <= '0;
                            r_rstSecond <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= RESET;
                        end
                    end
                end
                RESET: begin
                    r_rstSecond <= 1'b1;
                    if (r_rstSecond) begin
                        r_cpuRst <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (r_cyc != c_maxCyc) begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                    if (w_runEnd) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_cpuRst <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if ((r_state == RUN) || (r_state == DRAIN)) begin
                r_capValid <= 1'b1;
                r_capData  <= cpu_out;
            end else begin
                r_capValid <= 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign cpu_rst   = r_cpuRst;
    assign cap_valid = r_capValid;
    assign cap_data  = r_capData;

endmodule

`default_nettype wire

// File: tb/tb_hidden_cpu_feeder.sv
// ============================================================================
// Module  : tb_hidden_cpu_feeder
// Brief   : Self-checking bench for hidden_cpu_feeder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hidden_cpu_feeder;

    localparam int DEPTH = 32;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [5:0] load_data;
    logic       clear;
    logic       start;
    logic       follow_pc;
    logic       stop;
    logic       busy;
    logic       done;
    logic       cpu_rst;
    logic [5:0] cpu_instr;
    logic [7:0] cpu_out;
    logic       cap_valid;
    logic [7:0] cap_data;

    int nAsserts = 0;
    int nFail    = 0;

    // Reference program image as the host believes it was loaded.
    logic [5:0] prog [DEPTH];
    int         progLen = 0;
    logic [5:0] fixedW [3];

    typedef struct {
        int len;
        bit fol;
        int stopK;
        int outMode;
        bit reload;
        int expR;
    } vec_t;
    vec_t vecs [8];

    hidden_cpu_feeder #(
        .DEPTH      (32),
        .AW         (5),
        .MAX_CYCLES (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .clear      (clear),
        .start      (start),
        .follow_pc  (follow_pc),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .cpu_rst    (cpu_rst),
        .cpu_instr  (cpu_instr),
        .cpu_out    (cpu_out),
        .cap_valid  (cap_valid),
        .cap_data   (cap_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic loadProg(input int n, input bit useFixed);
        clear = 1'b1;
        @(posedge clk); #1;
        clear   = 1'b0;
        progLen = 0;
        while (progLen < n) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                @(posedge clk); #1;
                continue;
            end
            load_valid = 1'b1;
            load_data  = useFixed ? fixedW[progLen] : 6'($urandom);
            #1;
            chk("loadReady", load_ready, 1);
            prog[progLen] = load_data;
            progLen++;
            @(posedge clk); #1;
        end
        if (n == DEPTH) begin
            load_valid = 1'b1;
            load_data  = ~prog[0];
            #1;
            chk("fullNotReady", load_ready, 0);
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
    endtask

    // One run from start to one cycle past done; expectations derived from
    // the program image and the run-termination rules.
    task automatic runProg(input int len, input bit fol, input int stopK,
                           input int outMode, input int expR);
        int         drainT;
        int         busyCycles;
        int         runLen;
        int         k;
        bit         ended;
        bit         inRun;
        logic [7:0] outv;
        logic [7:0] prevOut;
        logic [5:0] expInstr;
        logic [7:0] pat [4];
        pat = '{8'd0, 8'd1, 8'd2, 8'd7};

        start     = 1'b1;
        follow_pc = fol;
        @(posedge clk); #1;
        start      = 1'b0;
        ended      = 1'b0;
        drainT     = 1000;
        busyCycles = 0;
        runLen     = 0;
        prevOut    = cpu_out;
        for (int t = 0; (t <= drainT + 2) && (t < 400); t++) begin
            k        = t - 2;
            inRun    = (t >= 2) && !ended;
            expInstr = '0;
            stop     = 1'b0;
            if (inRun) begin
                case (outMode)
                    1:       outv = (k < 4) ? pat[k] : 8'd7;
                    2:       outv = 8'd0;
                    3:       outv = 8'($urandom_range(0, len + 1));
                    default: outv = 8'($urandom);
                endcase
                stop = (k == stopK);
                runLen++;
                if (fol) begin
                    if (int'(outv) >= len) ended = 1'b1;
                    else expInstr = prog[outv[4:0]];
                end else begin
                    expInstr = prog[k];
                    if (k == len - 1) ended = 1'b1;
                end
                if ((k == 255) || stop) ended = 1'b1;
                if (ended) drainT = t + 1;
            end else begin
                outv = 8'($urandom);
            end
            cpu_out = outv;
            if (t <= drainT) begin
                start      = 1'($urandom);
                load_valid = 1'($urandom);
                clear      = 1'($urandom);
                follow_pc  = 1'($urandom);
                load_data  = 6'($urandom);
            end else begin
                start      = 1'b0;
                load_valid = 1'b0;
                clear      = 1'b0;
            end
            #1;
            chk("busy",      busy,      (t <= drainT));
            chk("cpuRst",    cpu_rst,   (t < 2) || (t > drainT));
            chk("done",      done,      (t == drainT + 1));
            chk("cpuInstr",  cpu_instr, expInstr);
            chk("capValid",  cap_valid, (t >= 3) && (t <= drainT + 1));
            chk("loadReady", load_ready, (t > drainT) && (len < DEPTH));
            if ((t >= 3) && (t <= drainT + 1)) chk("capData", cap_data, prevOut);
            if (busy === 1'b1) busyCycles++;
            prevOut = outv;
            @(posedge clk); #1;
        end
        chk("busyCycles", busyCycles, ((expR >= 0) ? expR : runLen) + 3);
        start = 1'b0; load_valid = 1'b0; clear = 1'b0; stop = 1'b0;
    endtask

    task automatic midRunReset();
        bit seenDone;
        loadProg(8, 1'b0);
        start     = 1'b1;
        follow_pc = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstBusy",     busy,       0);
        chk("rstCpuRst",   cpu_rst,    1);
        chk("rstCapValid", cap_valid,  0);
        chk("rstCapData",  cap_data,   0);
        chk("rstInstr",    cpu_instr,  0);
        chk("rstReady",    load_ready, 1);
        @(posedge clk); #2;
        rst_n    = 1'b1;
        progLen  = 0;
        seenDone = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seenDone = 1'b1;
        end
        chk("noDoneAfterRst", seenDone, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("countClearedByRst", busy, 0);
    endtask

    initial begin
        int  n;
        int  sk;
        bit  fol;
        bit  reuse;

        fixedW[0] = 6'h05; fixedW[1] = 6'h2A; fixedW[2] = 6'h3F;
        vecs[0] = '{3,  1'b0, -1, 0, 1'b1, 3};
        vecs[1] = '{32, 1'b0, -1, 0, 1'b1, 32};
        vecs[2] = '{4,  1'b1, -1, 1, 1'b1, 4};
        vecs[3] = '{8,  1'b0,  1, 0, 1'b1, 2};
        vecs[4] = '{1,  1'b1, -1, 2, 1'b1, 256};
        vecs[5] = '{1,  1'b0, -1, 0, 1'b1, 1};
        vecs[6] = '{5,  1'b0,  4, 0, 1'b1, 5};
        vecs[7] = '{5,  1'b0, -1, 0, 1'b0, 5};

        rst_n = 1'b0; load_valid = 1'b0; clear = 1'b0; start = 1'b0;
        follow_pc = 1'b0; stop = 1'b0; load_data = '0; cpu_out = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("resetReady",    load_ready, 1);
        chk("resetBusy",     busy,       0);
        chk("resetDone",     done,       0);
        chk("resetCpuRst",   cpu_rst,    1);
        chk("resetInstr",    cpu_instr,  0);
        chk("resetCapValid", cap_valid,  0);
        chk("resetCapData",  cap_data,   0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("startEmptyIgnored", busy, 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].reload) loadProg(vecs[i].len, (i == 0));
            runProg(progLen, vecs[i].fol, vecs[i].stopK, vecs[i].outMode, vecs[i].expR);
        end

        midRunReset();

        for (int i = 0; i < 24; i++) begin
            reuse = (progLen > 0) && ($urandom_range(0, 3) == 0);
            if (!reuse) begin
                n = $urandom_range(1, DEPTH);
                loadProg(n, 1'b0);
            end
            fol = 1'($urandom);
            sk  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, progLen + 1) : -1;
            runProg(progLen, fol, sk, fol ? 3 : 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

`default_nettype wire
